// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS fetch constants, state encoding and PC legality helper
package mips_pkg;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  function automatic logic pc_illegal(input logic [31:0] pc, input logic [31:0] last_pc);
    return (pc[1:0] != 2'b00) || (pc > last_pc);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, instruction memory and IF/ID signals of the fetch stage
interface fetch_unit_if;

  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] instruction;
  logic [31:0] readAddress;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;
  logic        fetchFault;
  logic [31:0] fetchCount;

  modport master (
    output stall, flush, redirect, redirectTarget, instruction,
    input  readAddress, ifidInstr, ifidPcPlus4, ifidValid, fetchFault, fetchCount
  );

  modport slave (
    input  stall, flush, redirect, redirectTarget, instruction,
    output readAddress, ifidInstr, ifidPcPlus4, ifidValid, fetchFault, fetchCount
  );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// rtl/fetch_unit_ifid_reg.sv - IF/ID pipeline register; bubble wins over hold, PC+4 kept across bubbles
module ifid_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, redirect/stall/flush handling and sticky fetch fault
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 512,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  import mips_pkg::*;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES) - INSTR_BYTES;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  cand_pc;
  logic         move_pc;
  logic         ifid_hold;
  logic         ifid_bubble;

  assign pc_plus4 = pc_q + INSTR_BYTES;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    count_d     = count_q;
    cand_pc     = pc_q;
    move_pc     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state_q)
      FETCH_RUN: begin
        if (bus.redirect) begin
          cand_pc     = bus.redirectTarget;
          move_pc     = 1'b1;
          ifid_bubble = 1'b1;
        end else if (bus.stall) begin
          ifid_bubble = bus.flush;
          ifid_hold   = ~bus.flush;
        end else begin
          cand_pc     = pc_plus4;
          move_pc     = 1'b1;
          ifid_bubble = bus.flush;
          if (!bus.flush) count_d = count_q + 32'd1;
        end
        // A bad next PC is never loaded; the IF/ID side of this edge is unaffected.
        if (move_pc) begin
          if (pc_illegal(cand_pc, LAST_PC)) begin
            state_d = FETCH_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = cand_pc;
          end
        end
      end
      FETCH_FAULT: begin
        ifid_bubble = 1'b1;
      end
      default: begin
        ifid_bubble = 1'b1;
      end
    endcase
  end

  ifid_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid_reg (
    .clk        (clk),
    .reset_i    (reset),
    .hold_i     (ifid_hold),
    .bubble_i   (ifid_bubble),
    .instr_i    (bus.instruction),
    .pc_plus4_i (pc_plus4),
    .instr_o    (bus.ifidInstr),
    .pc_plus4_o (bus.ifidPcPlus4),
    .valid_o    (bus.ifidValid)
  );

  assign bus.readAddress = pc_q;
  assign bus.fetchFault  = fault_q;
  assign bus.fetchCount  = count_q;

endmodule
